fmap_pack_writer: RTL and testbench

//  Upstream feeder for the feature-map BRAM copy stage. Accepts DATA_NUM feature

---
 rtl/fmap_pack_writer.sv | 144 ++++++++++++++
 tb/tb_fmap_pack_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_pack_writer.sv
// Packs a stream of I_F_BW-bit feature elements into 32-bit words (lane 0 in the LSBs)
// and writes them in address order to the infmap BRAM port, reporting idle/run/error/done.
module fmap_pack_writer #(
    parameter int DATA_NUM  = 400,
    parameter int I_F_BW    = 8,
    localparam int B_COL_NUM = 32 / I_F_BW,
    localparam int WORD_D    = (DATA_NUM + B_COL_NUM - 1) / B_COL_NUM,
    localparam int ADDR_W    = (WORD_D > 1) ? $clog2(WORD_D) : 1
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              i_run,
    output logic              o_idle,
    output logic              o_run,
    output logic              o_en_err,
    output logic              o_n_ready,
    output logic              o_ot_done,
    input  logic              i_data_valid,
    input  logic [I_F_BW-1:0] i_data,
    output logic              o_data_ready,
    output logic [ADDR_W-1:0] b_o_fmap_addr,
    output logic              b_o_fmap_ce,
    output logic              b_o_fmap_we,
    output logic [31:0]       b_o_fmap_d
);
    localparam int CNT_W  = $clog2(DATA_NUM + 1);
    localparam int LANE_W = (B_COL_NUM > 1) ? $clog2(B_COL_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [31:0]         pack_q, pack_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         pack_new;
    logic                accept, last_elem, lane_full;

    assign accept    = (state_q == S_RUN) && i_data_valid;
    assign last_elem = (cnt_q == CNT_W'(DATA_NUM - 1));
    assign lane_full = (lane_q == LANE_W'(B_COL_NUM - 1));

    always_comb begin
        pack_new = pack_q;
        for (int j = 0; j < B_COL_NUM; j++) begin
            if (lane_q == LANE_W'(j)) begin
                pack_new[j*I_F_BW +: I_F_BW] = i_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        word_d  = word_q;
        pack_d  = pack_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    pack_d  = '0;
                end
            end
            S_RUN: begin
                if (i_run) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A full word or the final element flushes; the pack register restarts empty.
                    if (lane_full || last_elem) begin
                        we_d    = 1'b1;
                        addr_d  = word_q;
                        wdata_d = pack_new;
                        pack_d  = '0;
                        lane_d  = '0;
                        word_d  = word_q + ADDR_W'(1);
                    end else begin
                        pack_d = pack_new;
                        lane_d = lane_q + LANE_W'(1);
                    end
                    if (last_elem) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (i_run) begin
                    err_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            pack_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            pack_q  <= pack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign o_idle        = (state_q == S_IDLE);
    assign o_run         = (state_q != S_IDLE);
    assign o_data_ready  = (state_q == S_RUN);
    assign o_n_ready     = (state_q == S_LAST);
    assign o_ot_done     = (state_q == S_DONE);
    assign o_en_err      = err_q;
    assign b_o_fmap_we   = we_q;
    assign b_o_fmap_ce   = we_q;
    assign b_o_fmap_addr = addr_q;
    assign b_o_fmap_d    = wdata_q;
endmodule

// File: tb/tb_fmap_pack_writer.sv
// Randomized bench for fmap_pack_writer: two instances (400 and 10 elements) checked
// every cycle against a stream-level model, plus literal BRAM image expectations.
module tb_fmap_pack_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic run0 = 0, valid0 = 0, run1 = 0, valid1 = 0;
    logic [7:0] data0 = 0, data1 = 0;
    logic idle0, runo0, err0, nrdy0, done0, rdy0, ce0, we0;
    logic idle1, runo1, err1, nrdy1, done1, rdy1, ce1, we1;
    logic [6:0] addr0;
    logic [1:0] addr1;
    logic [31:0] d0, d1;

    fmap_pack_writer #(.DATA_NUM(400), .I_F_BW(8)) u_dut0 (
        .clk(clk), .areset(rst), .i_run(run0), .o_idle(idle0), .o_run(runo0),
        .o_en_err(err0), .o_n_ready(nrdy0), .o_ot_done(done0),
        .i_data_valid(valid0), .i_data(data0), .o_data_ready(rdy0),
        .b_o_fmap_addr(addr0), .b_o_fmap_ce(ce0), .b_o_fmap_we(we0), .b_o_fmap_d(d0));

    fmap_pack_writer #(.DATA_NUM(10), .I_F_BW(8)) u_dut1 (
        .clk(clk), .areset(rst), .i_run(run1), .o_idle(idle1), .o_run(runo1),
        .o_en_err(err1), .o_n_ready(nrdy1), .o_ot_done(done1),
        .i_data_valid(valid1), .i_data(data1), .o_data_ready(rdy1),
        .b_o_fmap_addr(addr1), .b_o_fmap_ce(ce1), .b_o_fmap_we(we1), .b_o_fmap_d(d1));

    int checks = 0;
    int errors = 0;

    // Stream-level model state, one slot per instance.
    int          m_n[2] = '{400, 10};
    bit          m_busy[2], m_rdy[2], m_due[2], m_last[2], m_done[2], m_err[2];
    int          m_k[2], m_widx[2], m_addr[2];
    logic [31:0] m_word[2], m_dword[2];
    int          nwr[2], ndone[2];
    logic [31:0] img[2][128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int id);
        m_busy[id] = 0; m_rdy[id] = 0; m_due[id] = 0; m_last[id] = 0;
        m_done[id] = 0; m_err[id] = 0; m_k[id] = 0; m_widx[id] = 0;
        m_addr[id] = 0; m_word[id] = 0; m_dword[id] = 0;
    endtask

    task automatic model_cycle(input int id, input logic run, input logic valid,
                               input logic [7:0] data, input logic idle, input logic runo,
                               input logic err, input logic nrdy, input logic done,
                               input logic rdy, input logic we, input logic ce,
                               input int addr, input logic [31:0] d);
        bit nd;
        bit last_now;
        if (rst) begin
            chk("rst_idle", 32'(idle), 1);
            chk("rst_we", 32'(we), 0);
            chk("rst_ready", 32'(rdy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            model_reset(id);
            return;
        end
        chk("idle", 32'(idle), 32'(!m_busy[id]));
        chk("run", 32'(runo), 32'(m_busy[id]));
        chk("ready", 32'(rdy), 32'(m_rdy[id]));
        chk("we", 32'(we), 32'(m_due[id]));
        chk("ce", 32'(ce), 32'(m_due[id]));
        if (m_due[id]) begin
            chk("addr", 32'(addr), 32'(m_addr[id]));
            chk("wdata", d, m_dword[id]);
        end
        last_now = m_due[id] && m_last[id];
        chk("n_ready", 32'(nrdy), 32'(last_now));
        chk("ot_done", 32'(done), 32'(m_done[id]));
        chk("en_err", 32'(err), 32'(m_err[id]));
        if (we) begin
            $display("write inst=%0d addr=%0d data=%h t=%0t", id, addr, d, $time);
            img[id][addr] = d;
            nwr[id]++;
        end
        if (done) ndone[id]++;

        if (run && (m_rdy[id] || last_now)) m_err[id] = 1;
        nd = 0;
        if (valid && m_rdy[id]) begin
            m_word[id] = m_word[id] | (32'(data) << (8 * (m_k[id] % 4)));
            m_k[id]++;
            if ((m_k[id] % 4 == 0) || (m_k[id] == m_n[id])) begin
                nd = 1;
                m_dword[id] = m_word[id];
                m_addr[id]  = m_widx[id];
                m_widx[id]++;
                m_word[id]  = 0;
                m_last[id]  = (m_k[id] == m_n[id]);
                if (m_k[id] == m_n[id]) m_rdy[id] = 0;
            end
        end
        if (run && !m_busy[id]) begin
            m_busy[id] = 1; m_rdy[id] = 1; m_k[id] = 0; m_widx[id] = 0; m_word[id] = 0;
        end
        if (m_done[id]) m_busy[id] = 0;
        m_done[id] = last_now;
        m_due[id]  = nd;
    endtask

    always @(negedge clk) begin
        model_cycle(0, run0, valid0, data0, idle0, runo0, err0, nrdy0, done0, rdy0,
                    we0, ce0, int'(addr0), d0);
        model_cycle(1, run1, valid1, data1, idle1, runo1, err1, nrdy1, done1, rdy1,
                    we1, ce1, int'(addr1), d1);
    end

    task automatic set_run(input int id, input logic v);
        if (id == 0) run0 = v; else run1 = v;
    endtask

    task automatic set_in(input int id, input logic v, input logic [7:0] dat);
        if (id == 0) begin valid0 = v; data0 = dat; end
        else begin valid1 = v; data1 = dat; end
    endtask

    // Returns during the DONE cycle so a following call can start in the cycle after it.
    task automatic drive_run(input int id, input int n, input int duty, input int base,
                             input int stray_at, input int rst_at, input bit done_pulse);
        int k = 0;
        int cyc = 0;
        bit v;
        bit stray_done = 0;
        @(posedge clk); #2;
        set_run(id, 1);
        while (k < n) begin
            v = ($urandom_range(99) < duty);
            set_in(id, v, 8'((k + base) & 255));
            @(negedge clk); #1;
            if (v && ((id == 0) ? rdy0 : rdy1)) k++;
            @(posedge clk); #2;
            set_run(id, 0);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk("async_idle", 32'(idle0), 1);
                chk("async_run", 32'(runo0), 0);
                chk("async_ready", 32'(rdy0), 0);
                chk("async_we", 32'(we0), 0);
                chk("async_err", 32'(err0), 0);
                set_in(id, 0, 0);
                @(posedge clk); #2;
                rst = 1'b0;
                return;
            end
            if (k == stray_at && !stray_done) begin
                set_run(id, 1);
                stray_done = 1;
            end
            cyc++;
            if (cyc > 4 * n + 100) begin
                checks++; errors++;
                $display("FAIL timeout inst=%0d accepted=%0d required=%0d", id, k, n);
                set_in(id, 0, 0);
                return;
            end
        end
        set_in(id, 0, 0);
        @(posedge clk); #2;
        if (done_pulse) begin
            set_run(id, 1);
            @(posedge clk); #2;
            set_run(id, 0);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w, input int base, input int n);
        logic [31:0] r = 0;
        for (int j = 0; j < 4; j++)
            if (4 * w + j < n) r[8*j +: 8] = 8'((4 * w + j + base) & 255);
        return r;
    endfunction

    task automatic check_image(input int id, input int n, input int base);
        for (int w = 0; w < (n + 3) / 4; w++) chk("image", img[id][w], exp_word(w, base, n));
    endtask

    task automatic clear_stats(input int id);
        nwr[id] = 0; ndone[id] = 0;
        for (int w = 0; w < 128; w++) img[id][w] = 32'hDEADBEEF;
    endtask

    initial begin
        model_reset(0); model_reset(1);
        clear_stats(0); clear_stats(1);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_idle", 32'(idle0), 1);
        chk("reset_ready", 32'(rdy0), 0);
        chk("reset_addr_d", {25'd0, addr0} | d0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Continuous stream, stray i_run in the DONE cycle must be harmless.
        drive_run(0, 400, 100, 0, -1, -1, 1);
        repeat (3) @(posedge clk);
        chk("t1_nwrites", nwr[0], 100);
        chk("t1_word0", img[0][0], 32'h03020100);
        chk("t1_word99", img[0][99], 32'h8F8E8D8C);
        chk("t1_ndone", ndone[0], 1);
        chk("t1_no_err", 32'(err0), 0);
        chk("t1_idle", 32'(idle0), 1);

        // Partial last word on the 10-element instance.
        drive_run(1, 10, 100, 1, -1, -1, 0);
        repeat (3) @(posedge clk);
        chk("t2_nwrites", nwr[1], 3);
        chk("t2_word0", img[1][0], 32'h04030201);
        chk("t2_word1", img[1][1], 32'h08070605);
        chk("t2_word2", img[1][2], 32'h00000A09);

        // Random valid gaps.
        clear_stats(0);
        drive_run(0, 400, 50, 0, -1, -1, 0);
        repeat (3) @(posedge clk);
        chk("t3_nwrites", nwr[0], 100);
        check_image(0, 400, 0);

        // Stray i_run mid-transfer.
        clear_stats(0);
        drive_run(0, 400, 70, 0, 37, -1, 0);
        repeat (3) @(posedge clk);
        chk("t4_err", 32'(err0), 1);
        chk("t4_ndone", ndone[0], 1);
        chk("t4_nwrites", nwr[0], 100);
        check_image(0, 400, 0);

        // Async reset after 150 elements, then a clean run.
        drive_run(0, 400, 100, 0, -1, 150, 0);
        repeat (2) @(posedge clk);
        clear_stats(0);
        drive_run(0, 400, 80, 7, -1, -1, 0);
        repeat (3) @(posedge clk);
        chk("t5_nwrites", nwr[0], 100);
        chk("t5_err", 32'(err0), 0);
        check_image(0, 400, 7);

        // Back-to-back runs: second i_run in the cycle after DONE.
        clear_stats(0);
        drive_run(0, 400, 100, 0, -1, -1, 0);
        drive_run(0, 400, 90, 8'h33, -1, -1, 0);
        repeat (3) @(posedge clk);
        chk("t6_nwrites", nwr[0], 200);
        chk("t6_ndone", ndone[0], 2);
        check_image(0, 400, 8'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
